// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder; the sub line exists only
// when CLA_PIPE_SUB_EN is defined.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CLA_PIPE_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef CLA_PIPE_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`endif
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder (subtractor with CLA_PIPE_SUB_EN), GPS 4-bit groups per stage.
// Latency: STAGES = WIDTH/(4*GPS) cycles; one beat per cycle.
// Backpressure: whole pipe holds while out_valid & ~out_ready; in_ready = ~out_valid | out_ready.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GPS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    cla_pipe_adder_if.slave  bus
);
    localparam int SW     = 4 * GPS;
    localparam int STAGES = WIDTH / SW;

    if (GPS < 1 || WIDTH < SW || (WIDTH % SW) != 0) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a non-zero multiple of 4*GPS");
    end

    function automatic logic [4:0] cla4(input logic [3:0] p, input logic [3:0] g, input logic c0);
        logic [4:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    logic             vld_q [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic             c_q   [STAGES];
    logic             ovf_q;

    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_c [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];
    logic             c_d   [STAGES];
    logic             ovf_d;

    logic       sub_eff;
    logic       en;
    logic       accept;
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] cv;
    logic       carry;
    logic       c_msb;

`ifdef CLA_PIPE_SUB_EN
    assign sub_eff = bus.sub;
`else
    assign sub_eff = 1'b0;
`endif

    assign en            = ~vld_q[STAGES-1] | bus.out_ready;
    assign accept        = bus.in_valid & en;
    assign bus.in_ready  = en;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = sum_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
    assign bus.ovf       = ovf_q;

    // Stage k consumes bits [k*SW +: SW] of the skewed operands and appends them to the partial sum.
    always_comb begin
        src_a[0] = bus.a;
        src_b[0] = sub_eff ? ~bus.b : bus.b;
        src_s[0] = '0;
        src_c[0] = sub_eff | bus.cin;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = sum_q[k-1];
            src_c[k] = c_q[k-1];
        end
        p     = '0;
        g     = '0;
        cv    = '0;
        c_msb = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            carry    = src_c[k];
            sum_d[k] = src_s[k];
            for (int gi = 0; gi < GPS; gi++) begin
                p  = src_a[k][k*SW + 4*gi +: 4] ^ src_b[k][k*SW + 4*gi +: 4];
                g  = src_a[k][k*SW + 4*gi +: 4] & src_b[k][k*SW + 4*gi +: 4];
                cv = cla4(p, g, carry);
                sum_d[k][k*SW + 4*gi +: 4] = p ^ cv[3:0];
                if (k*SW + 4*gi + 4 == WIDTH) begin
                    c_msb = cv[3];
                end
                carry = cv[4];
            end
            c_d[k] = carry;
        end
        ovf_d = c_msb ^ c_d[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                c_q[k]   <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            vld_q[0] <= accept;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= sum_d[k];
                a_q[k]   <= src_a[k];
                b_q[k]   <= src_b[k];
                c_q[k]   <= c_d[k];
            end
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Randomised scoreboard bench for cla_pipe_adder; covers the subtract path when
// CLA_PIPE_SUB_EN is defined (then WIDTH 32, GPS 2).
module tb_cla_pipe_adder;
`ifdef CLA_PIPE_SUB_EN
    localparam int W = 32;
    localparam int G = 2;
`else
    localparam int W = 16;
    localparam int G = 1;
`endif
    localparam int ST = W / (4 * G);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(W)) bus();

    cla_pipe_adder #(.WIDTH(W), .GPS(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           cyc;
        int           stl;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   stalls = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    endtask

    // Plain integer arithmetic: add with carry, or subtract with no-borrow flag.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s);
        exp_t       r;
        logic [W:0] t;
        if (s) begin
            r.s = a - b;
            r.c = (a >= b);
            r.o = (a[W-1] != b[W-1]) && (r.s[W-1] != a[W-1]);
        end else begin
            t   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            r.s = t[W-1:0];
            r.c = t[W];
            r.o = (a[W-1] == b[W-1]) && (r.s[W-1] != a[W-1]);
        end
        r.cyc = 0;
        r.stl = 0;
        return r;
    endfunction

    // Monitor: retire, then stall bookkeeping, then accept; all on the falling edge.
    always @(negedge clk) begin
        logic sub_s;
        cyc++;
`ifdef CLA_PIPE_SUB_EN
        sub_s = bus.sub;
`else
        sub_s = 1'b0;
`endif
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 64'(bus.out_valid), 64'(0));
                end else begin
                    mon_e = q.pop_front();
                    check("sum", 64'(bus.sum), 64'(mon_e.s));
                    check("cout", 64'(bus.cout), 64'(mon_e.c));
                    check("ovf", 64'(bus.ovf), 64'(mon_e.o));
                    check("latency", 64'(cyc - mon_e.cyc), 64'(ST + stalls - mon_e.stl));
                end
            end
            if (bus.out_valid && !bus.out_ready) stalls++;
            if (bus.in_valid && bus.in_ready) begin
                mon_e     = model(bus.a, bus.b, bus.cin, sub_s);
                mon_e.cyc = cyc;
                mon_e.stl = stalls;
                q.push_back(mon_e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic s);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
`ifdef CLA_PIPE_SUB_EN
        bus.sub      = s;
`else
        if (s) bus.cin = c;
`endif
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        logic ok;
        ok = 1'b0;
        set_beat(1'b1, a, b, c, s);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            tick();
        end
        if (!ok) check("send_timeout", 64'(bus.in_ready), 64'(1));
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 300 && q.size() != 0; i++) tick();
        check("drain_empty", 64'(q.size()), 64'(0));
        repeat (ST + 2) tick();
    endtask

    logic [W-1:0] maxpos;
    logic         rsub;

    initial begin
        maxpos        = {1'b0, {(W-1){1'b1}}};
        bus.out_ready = 1'b1;
        set_beat(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) tick();
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_sum", 64'(bus.sum), 64'(0));
        check("rst_cout", 64'(bus.cout), 64'(0));
        check("rst_ovf", 64'(bus.ovf), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        rst = 1'b0;
        tick();

        send(W'(32'h1234), W'(32'h0FF1), 1'b0, 1'b0);
        drain();

        send('1, '0, 1'b1, 1'b0);
        send(maxpos, W'(1), 1'b0, 1'b0);
        drain();

        for (int i = 0; i < 32; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        drain();

        // Fill the pipe while the sink refuses, then hold a pending beat against the stall.
        bus.out_ready = 1'b0;
        for (int i = 0; i < ST; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        set_beat(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(bus.in_ready), 64'(0));
            check("bp_out_valid", 64'(bus.out_valid), 64'(1));
            if (q.size() != 0) check("bp_sum_hold", 64'(bus.sum), 64'(q[0].s));
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("simul_handshake", 64'(bus.in_ready & bus.in_valid & bus.out_valid), 64'(1));
        tick();
        bus.in_valid = 1'b0;
        drain();

        for (int i = 0; i < 80; i++) begin
`ifdef CLA_PIPE_SUB_EN
            rsub = 1'($urandom);
`else
            rsub = 1'b0;
`endif
            set_beat(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), rsub);
            bus.out_ready = 1'($urandom);
            tick();
        end
        bus.out_ready = 1'b1;
        drain();

        // Three beats in flight, oldest at the output, then an asynchronous reset.
        send(W'($urandom), W'($urandom), 1'b0, 1'b0);
        send(W'($urandom), W'($urandom), 1'b0, 1'b0);
        send(W'($urandom), W'($urandom), 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        q.delete();
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_sum", 64'(bus.sum), 64'(0));
        check("midrst_cout", 64'(bus.cout), 64'(0));
        repeat (2) tick();
        rst = 1'b0;
        tick();
        send(W'(5), W'(3), 1'b0, 1'b0);
        drain();

`ifdef CLA_PIPE_SUB_EN
        send(W'(5), W'(7), 1'b0, 1'b1);
        send(W'(32'h80000000), W'(1), 1'b0, 1'b1);
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
